// File: rtl/alu_control_md_pkg.sv
// Shared definitions for the ALU control block: MIPS funct encodings,
// ALU operation codes, op_alu class codes and the mult/div sequencer states.
package alu_ctl_pkg;

    // R-type funct field encodings
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_JALR = 6'b001001;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    // operation_alu codes
    localparam int ALU_AND  = 0;
    localparam int ALU_OR   = 1;
    localparam int ALU_ADD  = 2;
    localparam int ALU_SUB  = 3;
    localparam int ALU_SLL  = 4;
    localparam int ALU_SRL  = 5;
    localparam int ALU_XOR  = 6;
    localparam int ALU_SLT  = 7;
    localparam int ALU_NOR  = 8;
    localparam int ALU_LUI  = 9;
    localparam int ALU_ADDU = 10;
    localparam int ALU_SUBU = 11;
    localparam int ALU_SLTU = 12;

    // op_alu class codes from main control (0 means "decode by funct")
    localparam int OPC_RTYPE = 0;
    localparam int OPC_ADD   = 1;
    localparam int OPC_LUI   = 2;
    localparam int OPC_OR    = 3;
    localparam int OPC_AND   = 4;
    localparam int OPC_XOR   = 5;
    localparam int OPC_SUB   = 6;
    localparam int OPC_SLT   = 7;
    localparam int OPC_SLTU  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/alu_control_md_if.sv
// Bus between instruction decode / datapath and the ALU control block.
// Handshake: the sequencer accepts a mult/div request in any cycle where
// instr_valid is high, the request decodes, and stall is low; an instruction
// seen while stall is high must be held unchanged by the pipeline until stall
// drops. fsm_state is a debug view of the sequencer state.
// master: drives instr_valid/op_alu/funct; slave: the control block.
interface alu_control_md_if #(
    parameter int OP_W    = 4,
    parameter int FUNCT_W = 6,
    parameter int OPER_W  = 4
);
    import alu_ctl_pkg::*;

    logic               instr_valid;
    logic [OP_W-1:0]    op_alu;
    logic [FUNCT_W-1:0] funct;
    logic [OPER_W-1:0]  operation_alu;
    logic               jump;
    logic               link;
    logic               illegal;
    logic               md_start;
    logic               md_div;
    logic               md_signed;
    logic               md_busy;
    logic               hi_lo_we;
    logic               stall;
    md_state_e          fsm_state;

    modport master (
        output instr_valid, op_alu, funct,
        input  operation_alu, jump, link, illegal, md_start, md_div,
               md_signed, md_busy, hi_lo_we, stall, fsm_state
    );

    modport slave (
        input  instr_valid, op_alu, funct,
        output operation_alu, jump, link, illegal, md_start, md_div,
               md_signed, md_busy, hi_lo_we, stall, fsm_state
    );
endinterface

// File: rtl/alu_control_md_decode.sv
// alu_decode: purely combinational ALU control decode.
// Inputs : instr_valid, op_alu, funct
// Outputs: operation_alu, jump, link, illegal (independent of instr_valid),
//          md_req (valid mult/div instruction), hilo_rd (valid mfhi/mflo).
module alu_decode
    import alu_ctl_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int FUNCT_W = 6,
    parameter int OPER_W  = 4
) (
    input  logic               instr_valid,
    input  logic [OP_W-1:0]    op_alu,
    input  logic [FUNCT_W-1:0] funct,
    output logic [OPER_W-1:0]  operation_alu,
    output logic               jump,
    output logic               link,
    output logic               illegal,
    output logic               md_req,
    output logic               hilo_rd
);

    logic rtype;
    assign rtype = (op_alu == '0);

    always_comb begin
        operation_alu = '0;
        jump          = 1'b0;
        link          = 1'b0;
        illegal       = 1'b0;
        if (rtype) begin
            casez (funct)
                F_ADD:     operation_alu = OPER_W'(ALU_ADD);
                F_SUB:     operation_alu = OPER_W'(ALU_SUB);
                F_AND:     operation_alu = OPER_W'(ALU_AND);
                F_OR:      operation_alu = OPER_W'(ALU_OR);
                F_NOR:     operation_alu = OPER_W'(ALU_NOR);
                F_XOR:     operation_alu = OPER_W'(ALU_XOR);
                F_SRL:     operation_alu = OPER_W'(ALU_SRL);
                F_SLL:     operation_alu = OPER_W'(ALU_SLL);
                F_ADDU:    operation_alu = OPER_W'(ALU_ADDU);
                F_SUBU:    operation_alu = OPER_W'(ALU_SUBU);
                F_SLT:     operation_alu = OPER_W'(ALU_SLT);
                F_SLTU:    operation_alu = OPER_W'(ALU_SLTU);
                F_JR: begin
                    operation_alu = OPER_W'(ALU_ADD);
                    jump          = 1'b1;
                end
                F_JALR: begin
                    operation_alu = OPER_W'(ALU_ADD);
                    jump          = 1'b1;
                    link          = 1'b1;
                end
                // mult/div and HI/LO moves do not use the ALU
                6'b0110??: operation_alu = '0;
                F_MFHI:    operation_alu = '0;
                F_MFLO:    operation_alu = '0;
                default:   illegal = 1'b1;
            endcase
        end else begin
            case (op_alu)
                OP_W'(OPC_ADD):  operation_alu = OPER_W'(ALU_ADD);
                OP_W'(OPC_LUI):  operation_alu = OPER_W'(ALU_LUI);
                OP_W'(OPC_OR):   operation_alu = OPER_W'(ALU_OR);
                OP_W'(OPC_AND):  operation_alu = OPER_W'(ALU_AND);
                OP_W'(OPC_XOR):  operation_alu = OPER_W'(ALU_XOR);
                OP_W'(OPC_SUB):  operation_alu = OPER_W'(ALU_SUB);
                OP_W'(OPC_SLT):  operation_alu = OPER_W'(ALU_SLT);
                OP_W'(OPC_SLTU): operation_alu = OPER_W'(ALU_SLTU);
                default:         operation_alu = '0;
            endcase
        end
    end

    assign md_req  = instr_valid & rtype & (funct[5:2] == 4'b0110);
    assign hilo_rd = instr_valid & rtype & ((funct == F_MFHI) | (funct == F_MFLO));

endmodule

// File: rtl/alu_control_md.sv
// alu_control_md: ALU control decode plus the multi-cycle mult/div sequencer.
// Ports: clk, reset (async, active high), bus (alu_control_md_if.slave)
//   carrying instr_valid/op_alu/funct in and the decode, md_* sequencer,
//   hi_lo_we and stall outputs back to the datapath.
module alu_control_md
    import alu_ctl_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int FUNCT_W  = 6,
    parameter int OPER_W   = 4,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 8,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_control_md_if.slave   bus
);

    logic             md_req;
    logic             hilo_rd;
    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             start_q, start_nxt;
    logic             div_q, div_nxt;
    logic             sgn_q, sgn_nxt;

    alu_decode #(
        .OP_W    (OP_W),
        .FUNCT_W (FUNCT_W),
        .OPER_W  (OPER_W)
    ) u_decode (
        .instr_valid   (bus.instr_valid),
        .op_alu        (bus.op_alu),
        .funct         (bus.funct),
        .operation_alu (bus.operation_alu),
        .jump          (bus.jump),
        .link          (bus.link),
        .illegal       (bus.illegal),
        .md_req        (md_req),
        .hilo_rd       (hilo_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
            div_q   <= 1'b0;
            sgn_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            start_q <= start_nxt;
            div_q   <= div_nxt;
            sgn_q   <= sgn_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start_nxt = 1'b0;
        div_nxt   = div_q;
        sgn_nxt   = sgn_q;
        case (state)
            ST_IDLE: begin
                if (md_req) begin
                    state_nxt = ST_RUN;
                    start_nxt = 1'b1;
                    div_nxt   = bus.funct[1];
                    sgn_nxt   = ~bus.funct[0];
                    // counting down to zero gives exactly LAT cycles in RUN
                    cnt_nxt   = bus.funct[1] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
                end
            end
            ST_RUN: begin
                if (cnt == '0) state_nxt = ST_DONE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.md_start  = start_q;
    assign bus.md_div    = div_q;
    assign bus.md_signed = sgn_q;
    assign bus.md_busy   = (state != ST_IDLE);
    assign bus.hi_lo_we  = (state == ST_DONE);
    // Only instructions touching the mult/div unit or HI/LO wait on it.
    assign bus.stall     = (state != ST_IDLE) & (md_req | hilo_rd);
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: directed scenarios plus randomized instruction
// streams, compared against a cycle-numbered reference model.
module tb_alu_control_md;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 8;

    logic clk;
    logic reset;

    alu_control_md_if #(.OP_W(4), .FUNCT_W(6), .OPER_W(4)) bus ();

    alu_control_md #(
        .OP_W(4), .FUNCT_W(6), .OPER_W(4),
        .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    // reference tables: -1 marks an illegal R-type funct
    int ftab[64];
    int otab[16];

    // sequencer model: op occupies cycles m_start..m_end, hi_lo_we at m_end
    int cyc;
    int m_start;
    int m_end;
    int m_div;
    int m_sgn;

    int funct_pool[20];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic init_tables();
        for (int i = 0; i < 64; i++) ftab[i] = -1;
        ftab[6'b100000] = 2;  ftab[6'b100010] = 3;  ftab[6'b100100] = 0;
        ftab[6'b100101] = 1;  ftab[6'b100111] = 8;  ftab[6'b100110] = 6;
        ftab[6'b000010] = 5;  ftab[6'b000000] = 4;  ftab[6'b100001] = 10;
        ftab[6'b100011] = 11; ftab[6'b101010] = 7;  ftab[6'b101011] = 12;
        ftab[6'b001000] = 2;  ftab[6'b001001] = 2;
        ftab[6'b011000] = 0;  ftab[6'b011001] = 0;  ftab[6'b011010] = 0;
        ftab[6'b011011] = 0;  ftab[6'b010000] = 0;  ftab[6'b010010] = 0;
        for (int i = 0; i < 16; i++) otab[i] = 0;
        otab[1] = 2; otab[2] = 9; otab[3] = 1; otab[4] = 0;
        otab[5] = 6; otab[6] = 3; otab[7] = 7; otab[8] = 12;
        funct_pool = '{32, 34, 36, 37, 39, 38, 2, 0, 33, 35, 42, 43, 8, 9,
                       24, 25, 26, 27, 16, 18};
    endtask

    task automatic model_clear();
        m_start = -100;
        m_end   = -100;
        m_div   = 0;
        m_sgn   = 0;
    endtask

    // Driver: present one instruction for one cycle and check every output.
    task automatic step(input bit v, input int op, input int f);
        bit busy, mdreq, hilo;
        int e_op;
        bus.instr_valid = v;
        bus.op_alu      = 4'(op);
        bus.funct       = 6'(f);
        @(negedge clk);
        busy  = (cyc >= m_start) && (cyc <= m_end);
        mdreq = v && (op == 0) && ((f >> 2) == 6);
        hilo  = v && (op == 0) && (f == 16 || f == 18);
        if (op == 0) e_op = (ftab[f] < 0) ? 0 : ftab[f];
        else         e_op = otab[op];
        check("operation_alu", 32'(bus.operation_alu), 32'(e_op));
        check("jump", 32'(bus.jump), 32'(op == 0 && (f == 8 || f == 9)));
        check("link", 32'(bus.link), 32'(op == 0 && f == 9));
        check("illegal", 32'(bus.illegal), 32'(op == 0 && ftab[f] < 0));
        check("md_busy", 32'(bus.md_busy), 32'(busy));
        check("md_start", 32'(bus.md_start), 32'(cyc == m_start));
        check("hi_lo_we", 32'(bus.hi_lo_we), 32'(cyc == m_end));
        check("stall", 32'(bus.stall), 32'(busy && (mdreq || hilo)));
        check("md_div", 32'(bus.md_div), 32'(m_div));
        check("md_signed", 32'(bus.md_signed), 32'(m_sgn));
        if (!busy && mdreq) begin
            m_div   = (f >> 1) & 1;
            m_sgn   = (f & 1) ? 0 : 1;
            m_start = cyc + 1;
            m_end   = cyc + 1 + (m_div ? DIV_LAT : MULT_LAT);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset in mid-cycle; registered outputs must clear at once.
    task automatic reset_now();
        reset = 1'b1;
        #1;
        check("rst_md_start", 32'(bus.md_start), 32'd0);
        check("rst_md_div", 32'(bus.md_div), 32'd0);
        check("rst_md_signed", 32'(bus.md_signed), 32'd0);
        check("rst_hi_lo_we", 32'(bus.hi_lo_we), 32'd0);
        check("rst_md_busy", 32'(bus.md_busy), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        init_tables();
        model_clear();
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.op_alu      = '0;
        bus.funct       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.md_busy), 32'd0);
        check("reset_start", 32'(bus.md_start), 32'd0);
        check("reset_we", 32'(bus.hi_lo_we), 32'd0);
        reset = 1'b0;

        // decode sweep
        for (int f = 0; f < 64; f++) step(0, 0, f);
        for (int op = 1; op < 16; op++) step(1, op, $urandom_range(0, 63));

        // MULT alone
        step(1, 0, 24);
        idle(7);

        // DIVU with mflo waiting on HI/LO
        step(1, 0, 27);
        idle(2);
        for (int i = 0; i < 8; i++) step(1, 0, 18);
        idle(2);

        // MULT then DIV back to back: DIV held until the sequencer frees up
        step(1, 0, 24);
        for (int i = 0; i < 6; i++) step(1, 0, 26);
        idle(11);

        // reset in the middle of a MULT, then a clean MULT
        step(1, 0, 24);
        idle(2);
        reset_now();
        idle(8);
        step(1, 0, 25);
        idle(7);

        // ADD while busy is never stalled
        step(1, 0, 24);
        for (int i = 0; i < 5; i++) step(1, 0, 32);
        idle(2);

        // randomized instruction stream
        for (int i = 0; i < 600; i++) begin
            bit v;
            int op;
            int f;
            v  = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
            if ($urandom_range(0, 9) < 7) f = funct_pool[$urandom_range(0, 19)];
            else                          f = $urandom_range(0, 63);
            if ($urandom_range(0, 199) == 0) reset_now();
            else                             step(v, op, f);
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
- Parametrised next-generation ALU control for the MIPS datapath.
- Keeps the combinational OPAlu/Funct to ALU-operation decode and the jr jump flag, and adds jalr and an illegal-funct flag.
- Adds a sequencer for multi-cycle MULT/MULTU/DIV/DIVU that drives the external mult/div unit, HI/LO writes and pipeline stalls.
- Sits between the main control/instruction decode and the ALU plus mult/div unit.

Parameters:
- OP_W, 4, width of op_alu.
- FUNCT_W, 6, width of funct; must be 6 for MIPS encodings.
- OPER_W, 4, width of operation_alu.
- MULT_LAT, 4, cycles the mult/div unit needs for multiply; must be >= 1.
- DIV_LAT, 8, cycles for divide; must be >= 1.
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  current instruction is real (not a bubble).
- op_alu  in  OP_W  ALU op class from main control.
- funct  in  FUNCT_W  instruction funct field.
- operation_alu  out  OPER_W  ALU operation select (combinational).
- jump  out  1  jr/jalr register jump (combinational).
- link  out  1  jalr writes the return address (combinational).
- illegal  out  1  op_alu==0 with an unknown funct (combinational).
- md_start  out  1  one-cycle start pulse to the mult/div unit (registered).
- md_div  out  1  1=divide, 0=multiply; held while busy (registered).
- md_signed  out  1  signed operation; held while busy (registered).
- md_busy  out  1  sequencer not IDLE.
- hi_lo_we  out  1  write the mult/div result into HI/LO this cycle.
- stall  out  1  hold PC and suppress the current instruction's writeback (combinational).

Behaviour:
- Decode when op_alu==0, by funct → operation_alu:
  - 100000→2, 100010→3, 100100→0, 100101→1, 100111→8, 100110→6.
  - 000010→5, 000000→4, 100001→10, 100011→11, 101010→7.
  - 101011 (sltu)→12.
  - jr 001000 and jalr 001001→2 with jump=1; jalr also sets link=1.
  - Mult/div 0110xx and mfhi 010000 / mflo 010010→0, illegal=0.
  - Any other funct→0 with illegal=1.
- Decode when op_alu≠0 (op_alu→operation_alu): 1→2, 2→9, 3→1, 4→0, 5→6, 6→3, 7→7, 8→12. Any other value→0; illegal stays 0.
- Decode outputs depend only on op_alu/funct; they ignore instr_valid and state.
- md request: instr_valid & op_alu==0 & funct[5:2]==4'b0110.
  - funct[1]→md_div.
  - ~funct[0]→md_signed.
- hilo read: instr_valid & op_alu==0 & funct∈{010000,010010}.
- FSM states: IDLE, RUN, DONE.
  - IDLE + md request (accept): next state RUN; cnt←LAT−1, where LAT = DIV_LAT if divide else MULT_LAT; md_start←1 for exactly the first RUN cycle; md_div/md_signed latched.
  - RUN: if cnt==0 → DONE, else cnt←cnt−1. RUN therefore lasts exactly LAT cycles.
  - DONE: hi_lo_we=1 for this single cycle; next state IDLE.
- md_busy = (state≠IDLE).
- stall = (state≠IDLE) & (md request | hilo read).
  - A stalled md request is accepted in the cycle state returns to IDLE.
  - mfhi/mflo issued in DONE stalls once and proceeds the next cycle.
  - Non-md instructions never stall.
- Accept is not stalled: the md instruction retires in its own cycle.
- Reset (any time, including mid-RUN):
  - state=IDLE, cnt=0.
  - md_start, md_div, md_signed, hi_lo_we = 0.
  - The in-flight operation is discarded and no hi_lo_we is issued.
- Total latency: accept edge → hi_lo_we in cycle LAT+1 after accept. HI/LO are readable by the cycle after DONE.

Decomposition:
- Package alu_ctl_pkg: funct encodings, operation_alu codes (AND=0 … SLTU=12), op_alu class codes, FSM state enum.
- Sub-module alu_decode: the purely combinational decode (operation_alu, jump, link, illegal, md/hilo request detect).
- The top module holds the FSM and counter.

Test Plan:
- Decode sweep: op_alu=0 over every funct, plus op_alu 1..15 → table values; funct=001001 gives jump=1, link=1; funct=111111 gives illegal=1, operation_alu=0.
- MULT (funct=011000) accepted at cycle 0 with MULT_LAT=4 → md_start=1 at cycle 1 only, md_signed=1, md_div=0, md_busy cycles 1–5, hi_lo_we=1 at cycle 5 only.
- DIVU (011011) with DIV_LAT=8 → md_div=1, md_signed=0, hi_lo_we at cycle 9; mflo presented cycles 3–9 → stall=1 for those cycles, 0 at cycle 10.
- Back-to-back MULT then DIV → second request stalls until IDLE and is accepted the cycle after DONE; md_start pulses once per operation.
- reset asserted at cycle 3 of a MULT → all registered outputs 0 immediately (asynchronous), no hi_lo_we ever; a new MULT after reset release runs a normal full sequence.
- ADD (100000) while busy → stall=0, operation_alu=2.
